// File: rtl/mi_memtest_pkg.sv
// Shared definitions for the mi_memtest memory self-test initiator:
// FSM encodings, LFSR polynomial and the mi_len field width.
package mi_memtest_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_CMD  = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_CMD  = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_FIN     = 3'd5
    } state_e;

    // Galois form of x^32 + x^22 + x^2 + x + 1, shifting right.
    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    // Width of the mi_len field (words minus one, up to 128 words).
    localparam int MI_LEN_W = 7;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] nxt;
        nxt = s >> 1;
        if (s[0]) begin
            nxt = nxt ^ LFSR_POLY;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mi_lfsr32.sv
// 32-bit Galois LFSR with synchronous load and advance; load wins over advance.
module mi_lfsr32
    import mi_memtest_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h00000001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        adv_i,
    input  logic [31:0] seed_i,
    output logic [31:0] state_o
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    // Next-state selection: reload, step, or hold.
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (adv_i) begin
            state_d = lfsr_step(state_q);
        end else begin
            state_d = state_q;
        end
    end

    // LFSR state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/mi_memtest.sv
// Memory self-test initiator: writes an LFSR pattern over a region in fixed
// bursts, reads it back, and reports mismatches and rlast misplacement.
module mi_memtest
    import mi_memtest_pkg::*;
#(
    parameter int          AW        = 20,
    parameter int          BURST_LEN = 64,
    parameter logic [31:0] SEED      = 32'h00000001
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       cfg_base,
    input  logic [15:0]         cfg_nbursts,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [15:0]         err_cnt,
    output logic [AW-1:0]       err_addr,
    output logic                proto_err,
    output logic [AW-1:0]       mi_addr,
    output logic [MI_LEN_W-1:0] mi_len,
    output logic                mi_rw,
    output logic                mi_valid,
    input  logic                mi_ready,
    output logic [31:0]         mi_wdata,
    input  logic                mi_wack,
    input  logic                mi_wlast,
    input  logic [31:0]         mi_rdata,
    input  logic                mi_rstb,
    input  logic                mi_rlast
);

    localparam logic [AW-1:0]       BURST_STEP = AW'(BURST_LEN);
    localparam logic [7:0]          LAST_WORD  = 8'(BURST_LEN - 1);
    localparam logic [MI_LEN_W-1:0] LEN_VAL    = MI_LEN_W'(BURST_LEN - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [15:0]   nbursts_q, nbursts_d;
    logic [AW-1:0] cur_addr_q, cur_addr_d;
    logic [15:0]   burst_cnt_q, burst_cnt_d;
    logic [7:0]    word_cnt_q, word_cnt_d;
    logic [15:0]   err_cnt_q, err_cnt_d;
    logic [AW-1:0] err_addr_q, err_addr_d;
    logic          proto_err_q, proto_err_d;
    logic          pass_q, pass_d;

    logic          lfsr_load_s;
    logic          lfsr_adv_s;
    logic [31:0]   lfsr_state_s;
    logic [AW-1:0] rd_addr_s;

    // Address of the read word currently expected (wraps with AW).
    assign rd_addr_s = cur_addr_q + AW'(word_cnt_q);

    mi_lfsr32 #(
        .SEED(SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load_i (lfsr_load_s),
        .adv_i  (lfsr_adv_s),
        .seed_i (SEED),
        .state_o(lfsr_state_s)
    );

    // Sequencer: next state, burst/word bookkeeping and result accumulation.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        nbursts_d   = nbursts_q;
        cur_addr_d  = cur_addr_q;
        burst_cnt_d = burst_cnt_q;
        word_cnt_d  = word_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_addr_d  = err_addr_q;
        proto_err_d = proto_err_q;
        pass_d      = pass_q;
        lfsr_load_s = 1'b0;
        lfsr_adv_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d      = cfg_base;
                    nbursts_d   = cfg_nbursts;
                    cur_addr_d  = cfg_base;
                    burst_cnt_d = 16'd0;
                    word_cnt_d  = 8'd0;
                    err_cnt_d   = 16'd0;
                    err_addr_d  = '0;
                    proto_err_d = 1'b0;
                    lfsr_load_s = 1'b1;
                    if (cfg_nbursts == 16'd0) begin
                        pass_d  = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        pass_d  = 1'b0;
                        state_d = ST_WR_CMD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_CMD: begin
                if (mi_ready) begin
                    state_d = ST_WR_DATA;
                end else begin
                    state_d = ST_WR_CMD;
                end
            end
            ST_WR_DATA: begin
                if (mi_wack) begin
                    lfsr_adv_s = 1'b1;
                    if (mi_wlast) begin
                        cur_addr_d  = cur_addr_q + BURST_STEP;
                        burst_cnt_d = burst_cnt_q + 16'd1;
                        if (burst_cnt_d != nbursts_q) begin
                            state_d = ST_WR_CMD;
                        end else begin
                            // Write phase complete: rewind for read-back.
                            state_d     = ST_RD_CMD;
                            cur_addr_d  = base_q;
                            burst_cnt_d = 16'd0;
                            lfsr_load_s = 1'b1;
                        end
                    end else begin
                        state_d = ST_WR_DATA;
                    end
                end else begin
                    state_d = ST_WR_DATA;
                end
            end
            ST_RD_CMD: begin
                if (mi_ready) begin
                    word_cnt_d = 8'd0;
                    state_d    = ST_RD_DATA;
                end else begin
                    state_d = ST_RD_CMD;
                end
            end
            ST_RD_DATA: begin
                if (mi_rstb) begin
                    lfsr_adv_s = 1'b1;
                    if (mi_rdata != lfsr_state_s) begin
                        if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_d = err_cnt_q + 16'd1;
                        end else begin
                            err_cnt_d = err_cnt_q;
                        end
                        if (err_cnt_q == 16'd0) begin
                            err_addr_d = rd_addr_s;
                        end else begin
                            err_addr_d = err_addr_q;
                        end
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                    if (mi_rlast && (word_cnt_q != LAST_WORD)) begin
                        proto_err_d = 1'b1;
                    end else begin
                        proto_err_d = proto_err_q;
                    end
                    // The burst ends on the BURST_LEN-th strobe regardless of rlast.
                    if (word_cnt_q == LAST_WORD) begin
                        word_cnt_d  = 8'd0;
                        cur_addr_d  = cur_addr_q + BURST_STEP;
                        burst_cnt_d = burst_cnt_q + 16'd1;
                        if (burst_cnt_d != nbursts_q) begin
                            state_d = ST_RD_CMD;
                        end else begin
                            // Result is ready in the same cycle as done.
                            pass_d  = (err_cnt_d == 16'd0) && !proto_err_d;
                            state_d = ST_FIN;
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + 8'd1;
                        state_d    = ST_RD_DATA;
                    end
                end else begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            nbursts_q   <= 16'd0;
            cur_addr_q  <= '0;
            burst_cnt_q <= 16'd0;
            word_cnt_q  <= 8'd0;
            err_cnt_q   <= 16'd0;
            err_addr_q  <= '0;
            proto_err_q <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            nbursts_q   <= nbursts_d;
            cur_addr_q  <= cur_addr_d;
            burst_cnt_q <= burst_cnt_d;
            word_cnt_q  <= word_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_addr_q  <= err_addr_d;
            proto_err_q <= proto_err_d;
            pass_q      <= pass_d;
        end
    end

    // All outputs are decoded from registered state only.
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FIN);
    assign pass      = pass_q;
    assign err_cnt   = err_cnt_q;
    assign err_addr  = err_addr_q;
    assign proto_err = proto_err_q;
    assign mi_valid  = (state_q == ST_WR_CMD) || (state_q == ST_RD_CMD);
    assign mi_rw     = (state_q == ST_RD_CMD) || (state_q == ST_RD_DATA);
    assign mi_addr   = cur_addr_q;
    assign mi_len    = LEN_VAL;
    assign mi_wdata  = lfsr_state_s;

endmodule

// File: tb/tb_mi_memtest.sv
// Scoreboard bench for mi_memtest with a memory-model responder.
module tb_mi_memtest;

    localparam int AW = 20;
    localparam int BL = 16;
    localparam logic [31:0] SEED = 32'h00000001;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] cfg_base = '0;
    logic [15:0]   cfg_nbursts = 16'd0;
    logic          start = 1'b0;
    logic          busy, done, pass, proto_err;
    logic [15:0]   err_cnt;
    logic [AW-1:0] err_addr, mi_addr;
    logic [6:0]    mi_len;
    logic          mi_rw, mi_valid;
    logic          mi_ready, mi_wack, mi_wlast, mi_rstb, mi_rlast;
    logic [31:0]   mi_wdata, mi_rdata;

    mi_memtest #(.AW(AW), .BURST_LEN(BL), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .cfg_base(cfg_base), .cfg_nbursts(cfg_nbursts),
        .start(start), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .err_addr(err_addr), .proto_err(proto_err), .mi_addr(mi_addr),
        .mi_len(mi_len), .mi_rw(mi_rw), .mi_valid(mi_valid), .mi_ready(mi_ready),
        .mi_wdata(mi_wdata), .mi_wack(mi_wack), .mi_wlast(mi_wlast),
        .mi_rdata(mi_rdata), .mi_rstb(mi_rstb), .mi_rlast(mi_rlast)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic rw; logic [AW-1:0] addr; } cmd_t;
    typedef struct packed { logic pass; logic [15:0] cnt; logic [AW-1:0] eaddr; logic proto; } res_t;

    cmd_t        cmd_q[$];
    logic [31:0] wd_q[$];
    res_t        res_q[$];
    logic [31:0] mem [int];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int valid_cnt = 0;
    int rd_strobes = 0;
    bit inject = 1'b0;
    bit early_rlast = 1'b0;

    function automatic logic [31:0] lfsr_model(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_mem(input logic [AW-1:0] a, input logic [31:0] exp);
        logic [31:0] v;
        v = mem.exists(int'(a)) ? mem[int'(a)] : 32'hDEADBEEF;
        check("mem_word", {12'd0, a, v}, {12'd0, a, exp});
    endtask

    // Monitor: pops and compares whenever the DUT presents something.
    initial begin
        cmd_t        c;
        logic [31:0] w;
        res_t        r;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mi_valid) valid_cnt++;
                if (mi_valid && mi_ready) begin
                    if (cmd_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL cmd_unexpected actual=%0h required=none", mi_addr);
                    end else begin
                        c = cmd_q.pop_front();
                        check("cmd_rw", 64'(mi_rw), 64'(c.rw));
                        check("cmd_addr", 64'(mi_addr), 64'(c.addr));
                        check("cmd_len", 64'(mi_len), 64'd15);
                    end
                end
                if (mi_wack) begin
                    if (wd_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL wdata_unexpected actual=%0h required=none", mi_wdata);
                    end else begin
                        w = wd_q.pop_front();
                        check("wdata", 64'(mi_wdata), 64'(w));
                    end
                end
                if (done) begin
                    done_cnt++;
                    if (res_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL done_unexpected actual=1 required=0");
                    end else begin
                        r = res_q.pop_front();
                        check("pass", 64'(pass), 64'(r.pass));
                        check("err_cnt", 64'(err_cnt), 64'(r.cnt));
                        check("err_addr", 64'(err_addr), 64'(r.eaddr));
                        check("proto_err", 64'(proto_err), 64'(r.proto));
                    end
                end
            end
        end
    end

    // Responder: memory model that accepts commands and streams burst data.
    initial begin
        int            phase;
        int            cnt;
        int            seen;
        bit            gapped;
        logic [AW-1:0] raddr;
        logic [AW-1:0] a;
        logic          rrw;
        logic [31:0]   d;
        phase = 0; cnt = 0; seen = 0; gapped = 1'b0; raddr = '0; rrw = 1'b0;
        mi_ready = 1'b0; mi_wack = 1'b0; mi_wlast = 1'b0;
        mi_rstb = 1'b0; mi_rlast = 1'b0; mi_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                phase = 0; cnt = 0; seen = 0;
                mi_ready = 1'b0; mi_wack = 1'b0; mi_wlast = 1'b0;
                mi_rstb = 1'b0; mi_rlast = 1'b0; mi_rdata = 32'd0;
            end else begin
                if (mi_ready) begin
                    phase = 1; cnt = 0; gapped = 1'b0; seen = 0;
                end else if (phase == 1 && (mi_wack || mi_rstb)) begin
                    cnt++;
                    if (cnt == BL) phase = 0;
                end
                mi_ready = 1'b0; mi_wack = 1'b0; mi_wlast = 1'b0;
                mi_rstb = 1'b0; mi_rlast = 1'b0; mi_rdata = 32'd0;
                if (phase == 0) begin
                    if (mi_valid) begin
                        // Hold off one cycle so the command must stay stable.
                        if (seen >= 1) begin
                            mi_ready = 1'b1; raddr = mi_addr; rrw = mi_rw;
                        end
                        seen++;
                    end else begin
                        seen = 0;
                    end
                end else if (cnt == 3 && !gapped) begin
                    gapped = 1'b1;
                end else begin
                    a = raddr + AW'(cnt);
                    if (!rrw) begin
                        mi_wack = 1'b1;
                        mi_wlast = (cnt == BL - 1);
                        mem[int'(a)] = mi_wdata;
                    end else begin
                        d = mem.exists(int'(a)) ? mem[int'(a)] : 32'd0;
                        if (inject && rd_strobes == 4) d = d ^ 32'd1;
                        rd_strobes++;
                        mi_rdata = d;
                        mi_rstb = 1'b1;
                        mi_rlast = (cnt == BL - 1) || (early_rlast && cnt == 13);
                    end
                end
            end
        end
    end

    // Queue expected commands and write data for one test run.
    task automatic expect_traffic(input logic [AW-1:0] base, input int nb);
        logic [31:0] s;
        for (int b = 0; b < nb; b++) cmd_q.push_back('{1'b0, base + AW'(b * BL)});
        for (int b = 0; b < nb; b++) cmd_q.push_back('{1'b1, base + AW'(b * BL)});
        s = SEED;
        for (int i = 0; i < nb * BL; i++) begin
            wd_q.push_back(s);
            s = lfsr_model(s);
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] base, input logic [15:0] nb);
        @(posedge clk); #1;
        cfg_base = base; cfg_nbursts = nb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 8000 && done_cnt == d0; i++) @(posedge clk);
        if (done_cnt == d0) begin
            checks++; errors++;
            $display("FAIL done_timeout actual=0 required=1");
        end
        @(posedge clk); #2;
        check("busy_after_done", 64'(busy), 64'd0);
        check("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
        check("wd_q_drained", 64'(wd_q.size()), 64'd0);
    endtask

    task automatic run(input logic [AW-1:0] base, input int nb, input bit inj,
                       input bit early, input res_t exp, input bit poke);
        int d0;
        inject = inj; early_rlast = early; rd_strobes = 0;
        expect_traffic(base, nb);
        res_q.push_back(exp);
        d0 = done_cnt;
        pulse_start(base, 16'(nb));
        check("busy_after_start", 64'(busy), 64'd1);
        if (poke) begin
            repeat (5) @(posedge clk);
            #1;
            cfg_base = 20'h55555; cfg_nbursts = 16'd7; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        wait_done(d0);
        repeat (20) @(posedge clk);
        check("single_done", 64'(done_cnt), 64'(d0 + 1));
        inject = 1'b0; early_rlast = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int d0;
        logic [31:0] s;
        logic [31:0] seq [32];

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pass", 64'(pass), 64'd0);
        check("rst_proto", 64'(proto_err), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        check("rst_err_addr", 64'(err_addr), 64'd0);
        check("rst_mi_valid", 64'(mi_valid), 64'd0);

        // Clean run with a start pulse while busy.
        run(20'h00100, 4, 1'b0, 1'b0, '{1'b1, 16'd0, 20'h0, 1'b0}, 1'b1);
        check_mem(20'h00100, 32'h00000001);
        check_mem(20'h00101, 32'h80200003);
        check_mem(20'h00102, 32'hC0300002);
        check_mem(20'h00103, 32'h60180001);

        // Single corrupted read word on the 5th strobe.
        run(20'h00100, 4, 1'b1, 1'b0, '{1'b0, 16'd1, 20'h00104, 1'b0}, 1'b0);

        // Region wrapping past the top of the address space.
        run(20'hFFFF8, 2, 1'b0, 1'b0, '{1'b1, 16'd0, 20'h0, 1'b0}, 1'b0);
        s = SEED;
        for (int k = 0; k < 32; k++) begin
            seq[k] = s;
            s = lfsr_model(s);
        end
        check_mem(20'hFFFF8, seq[0]);
        check_mem(20'hFFFFF, seq[7]);
        check_mem(20'h00000, seq[8]);
        check_mem(20'h00017, seq[31]);

        // Zero bursts: no traffic, one FIN cycle.
        v0 = valid_cnt;
        d0 = done_cnt;
        res_q.push_back('{1'b1, 16'd0, 20'h0, 1'b0});
        pulse_start(20'h00700, 16'd0);
        check("nb0_busy", 64'(busy), 64'd1);
        check("nb0_done", 64'(done), 64'd1);
        check("nb0_pass", 64'(pass), 64'd1);
        @(posedge clk); #1;
        check("nb0_busy_drop", 64'(busy), 64'd0);
        check("nb0_done_drop", 64'(done), 64'd0);
        repeat (5) @(posedge clk);
        check("nb0_no_valid", 64'(valid_cnt), 64'(v0));
        check("nb0_done_cnt", 64'(done_cnt), 64'(d0 + 1));

        // Misplaced rlast on word 14 of 16.
        run(20'h00300, 1, 1'b0, 1'b1, '{1'b0, 16'd0, 20'h0, 1'b1}, 1'b0);
        check("proto_idle", 64'(busy), 64'd0);

        // Reset during the second write burst, then a fresh passing run.
        expect_traffic(20'h00200, 4);
        pulse_start(20'h00200, 16'd4);
        for (int i = 0; i < 2000 && cmd_q.size() > 6; i++) @(posedge clk);
        if (cmd_q.size() > 6) begin
            checks++; errors++;
            $display("FAIL reset_setup_timeout actual=%0d required=6", cmd_q.size());
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("rstmid_valid", 64'(mi_valid), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        @(posedge clk); #2;
        cmd_q.delete(); wd_q.delete(); res_q.delete();
        run(20'h00400, 2, 1'b0, 1'b0, '{1'b1, 16'd0, 20'h0, 1'b0}, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
